// File: rtl/sokoban_man_move.sv
// sokoban_man_move
//   Single-step player-movement engine for an 8x8 Sokoban board. A start
//   strobe samples the packed game state and a target cursor cell. The
//   engine moves the man one cell toward the cursor, pushing a box when
//   that is legal. It registers the updated state and a success flag, and
//   pulses done one cycle later.
//
//   Ports:
//     clk             system clock
//     rst             synchronous active-high reset
//     start           one-cycle request strobe; samples game_state/cursor
//     game_state      packed state {floor[63:0], box[63:0], row[2:0], col[2:0]}
//     cursor          target cell {row[2:0], col[2:0]}
//     game_state_next registered updated state
//     result          registered: 1 = man moved, 0 = rejected / no move
//     done            one-cycle pulse in the cycle after start
module sokoban_man_move (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [133:0] game_state,
  input  logic [5:0]   cursor,
  output logic [133:0] game_state_next,
  output logic         result,
  output logic         done
);

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  dir_t         dir;
  logic [63:0]  floor_plane;
  logic [63:0]  box_plane;
  logic [63:0]  next_floor;
  logic [63:0]  next_box;
  logic [2:0]   man_row;
  logic [2:0]   man_col;
  logic [2:0]   cur_row;
  logic [2:0]   cur_col;
  logic [2:0]   n_row;
  logic [2:0]   n_col;
  logic [2:0]   n2_row;
  logic [2:0]   n2_col;
  logic         n_in;
  logic         n2_in;
  logic [5:0]   n_idx;
  logic [5:0]   n2_idx;
  logic         n_box;
  logic         n_floor;
  logic         n2_floor;
  logic         do_step;
  logic         do_push;
  logic [133:0] next_state;
  logic         next_result;

  always_comb begin
    floor_plane = game_state[133:70];
    box_plane   = game_state[69:6];
    man_row     = game_state[5:3];
    man_col     = game_state[2:0];
    cur_row     = cursor[5:3];
    cur_col     = cursor[2:0];

    dir = DIR_NONE;
    if (cur_row < man_row)      dir = DIR_UP;
    else if (cur_row > man_row) dir = DIR_DOWN;
    else if (cur_col < man_col) dir = DIR_LEFT;
    else if (cur_col > man_col) dir = DIR_RIGHT;

    // Coordinates may wrap in 3 bits; the in-bounds flags gate every use.
    n_row  = man_row;
    n_col  = man_col;
    n2_row = man_row;
    n2_col = man_col;
    n_in   = 1'b0;
    n2_in  = 1'b0;
    case (dir)
      DIR_UP: begin
        n_in   = (man_row != 3'd0);
        n2_in  = (man_row > 3'd1);
        n_row  = man_row - 3'd1;
        n2_row = man_row - 3'd2;
      end
      DIR_DOWN: begin
        n_in   = (man_row != 3'd7);
        n2_in  = (man_row < 3'd6);
        n_row  = man_row + 3'd1;
        n2_row = man_row + 3'd2;
      end
      DIR_LEFT: begin
        n_in   = (man_col != 3'd0);
        n2_in  = (man_col > 3'd1);
        n_col  = man_col - 3'd1;
        n2_col = man_col - 3'd2;
      end
      DIR_RIGHT: begin
        n_in   = (man_col != 3'd7);
        n2_in  = (man_col < 3'd6);
        n_col  = man_col + 3'd1;
        n2_col = man_col + 3'd2;
      end
      default: ;
    endcase

    // Row r sits at plane bits [63-8r:56-8r], so bit index = 8*(7-r)+c = {~r, c}.
    n_idx  = {~n_row, n_col};
    n2_idx = {~n2_row, n2_col};

    // Box takes precedence over floor when classifying a cell.
    n_box    = box_plane[n_idx];
    n_floor  = !box_plane[n_idx] && floor_plane[n_idx];
    n2_floor = !box_plane[n2_idx] && floor_plane[n2_idx];

    do_step = n_in && n_floor;
    do_push = n_in && n_box && n2_in && n2_floor;

    next_floor  = floor_plane;
    next_box    = box_plane;
    next_state  = game_state;
    next_result = 1'b0;
    if (do_step) begin
      next_state[5:0] = {n_row, n_col};
      next_result     = 1'b1;
    end else if (do_push) begin
      next_box[n_idx]    = 1'b0;
      next_floor[n_idx]  = 1'b1;
      next_box[n2_idx]   = 1'b1;
      next_floor[n2_idx] = 1'b0;
      next_state         = {next_floor, next_box, n_row, n_col};
      next_result        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      game_state_next <= '0;
      result          <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        game_state_next <= next_state;
        result          <= next_result;
      end
    end
  end

endmodule

// File: tb/tb_sokoban_man_move.sv
// Testbench for sokoban_man_move: directed scenarios plus randomized chained
// moves. Expected results come from a board-array reference model and are
// queued; a monitor compares them whenever done is seen.
module tb_sokoban_man_move;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [133:0] gs;
  logic [5:0]   cur;
  logic [133:0] gsn;
  logic         res;
  logic         done;

  typedef struct {
    logic [133:0] st;
    logic         res;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  logic [133:0] last_st;
  logic         last_res;

  sokoban_man_move dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .game_state      (gs),
    .cursor          (cur),
    .game_state_next (gsn),
    .result          (res),
    .done            (done)
  );

  always #5 clk = ~clk;

  function automatic bit inb(input int r, input int c);
    return (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
  endfunction

  // Reference model on 2-D board arrays.
  function automatic void ref_move(input logic [133:0] s, input logic [5:0] c_in,
                                   output logic [133:0] ns, output logic r_out);
    bit fl[8][8];
    bit bx[8][8];
    int mr, mc, cr, cc, dr, dc, nr, nc, r2, c2;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        fl[r][c] = s[70 + 56 - 8*r + c];
        bx[r][c] = s[6 + 56 - 8*r + c];
      end
    mr = int'(s[5:3]);
    mc = int'(s[2:0]);
    cr = int'(c_in[5:3]);
    cc = int'(c_in[2:0]);
    dr = 0;
    dc = 0;
    if (cr < mr)      dr = -1;
    else if (cr > mr) dr = 1;
    else if (cc < mc) dc = -1;
    else if (cc > mc) dc = 1;
    ns    = s;
    r_out = 1'b0;
    if (dr == 0 && dc == 0) return;
    nr = mr + dr;
    nc = mc + dc;
    r2 = nr + dr;
    c2 = nc + dc;
    if (!inb(nr, nc)) return;
    if (bx[nr][nc]) begin
      if (!inb(r2, c2)) return;
      if (bx[r2][c2] || !fl[r2][c2]) return;
      bx[nr][nc] = 1'b0;
      fl[nr][nc] = 1'b1;
      bx[r2][c2] = 1'b1;
      fl[r2][c2] = 1'b0;
    end else if (!fl[nr][nc]) begin
      return;
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ns[70 + 56 - 8*r + c] = fl[r][c];
        ns[6 + 56 - 8*r + c]  = bx[r][c];
      end
    ns[5:3] = nr[2:0];
    ns[2:0] = nc[2:0];
    r_out   = 1'b1;
  endfunction

  function automatic logic [63:0] set_row(input logic [63:0] p, input int r, input logic [7:0] v);
    p[56 - 8*r +: 8] = v;
    return p;
  endfunction

  function automatic logic [133:0] mk(input logic [63:0] f, input logic [63:0] b,
                                      input logic [2:0] r, input logic [2:0] c);
    return {f, b, r, c};
  endfunction

  function automatic logic [133:0] rnd_state();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[133:0];
  endfunction

  task automatic chk(input string name, input logic [133:0] got, input logic [133:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [133:0] s, input logic [5:0] c,
                       output logic [133:0] ns, output logic r);
    exp_t e;
    ref_move(s, c, ns, r);
    gs    = s;
    cur   = c;
    start = 1'b1;
    e.st  = ns;
    e.res = r;
    sb.push_back(e);
    last_st  = ns;
    last_res = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic hold_check();
    repeat (3) @(negedge clk);
    chk("hold_done", {133'd0, done}, 134'd0);
    chk("hold_state", gsn, last_st);
    chk("hold_result", {133'd0, res}, {133'd0, last_res});
  endtask

  task automatic reset_check(input string tag);
    rst   = 1'b1;
    start = 1'b1;
    gs    = rnd_state();
    cur   = 6'($urandom);
    @(negedge clk);
    chk({tag, "_state"}, gsn, 134'd0);
    chk({tag, "_result"}, {133'd0, res}, 134'd0);
    chk({tag, "_done"}, {133'd0, done}, 134'd0);
    rst   = 1'b0;
    start = 1'b0;
    last_st  = '0;
    last_res = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL unexpected_done: done=1 with no request pending, got state=%h result=%b", gsn, res);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (gsn !== e.st || res !== e.res) begin
          failed++;
          $display("FAIL txn: got state=%h result=%b, expected state=%h result=%b",
                   gsn, res, e.st, e.res);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  f, b;
    logic [133:0] s, ns;
    logic         r;

    rst   = 1'b1;
    start = 1'b0;
    gs    = '0;
    cur   = '0;
    repeat (2) @(negedge clk);
    reset_check("reset_start");

    // Plain moves and wall stop.
    f = '0;
    for (int i = 1; i <= 6; i++) f = set_row(f, i, 8'b00000110);
    s = mk(f, '0, 3'd1, 3'd1);
    for (int i = 0; i < 3; i++) begin
      issue(s, {3'd2, 3'd7}, ns, r);
      s = ns;
    end
    hold_check();

    // Row 0 is wall: up from (1,1) blocked.
    issue(mk(f, '0, 3'd1, 3'd1), {3'd0, 3'd0}, ns, r);

    // Row 7 all floor: walk left to column 0, then no move.
    s = mk(set_row(f, 7, 8'hFF), '0, 3'd7, 3'd3);
    for (int i = 0; i < 4; i++) begin
      issue(s, {3'd7, 3'd0}, ns, r);
      s = ns;
    end

    // Push off the left edge and off the top edge: blocked.
    issue(mk(set_row(f, 7, 8'b11111110), set_row('0, 7, 8'b00000001), 3'd7, 3'd1),
          {3'd7, 3'd0}, ns, r);
    issue(mk(f, set_row('0, 0, 8'b00001000), 3'd1, 3'd3), {3'd0, 3'd3}, ns, r);

    // Box push then blocked push against a second box.
    f = '0;
    b = '0;
    for (int i = 1; i <= 5; i += 2) f = set_row(f, i, 8'b01111110);
    for (int i = 2; i <= 6; i += 2) begin
      f = set_row(f, i, 8'b01010110);
      b = set_row(b, i, 8'b00101000);
    end
    s = mk(f, b, 3'd1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      issue(s, {3'd2, 3'd7}, ns, r);
      s = ns;
    end

    // No move: cursor on the man.
    issue(s, s[5:0], ns, r);
    hold_check();

    // Reset overrides a simultaneous start.
    reset_check("reset_mid");

    // Randomized chained moves with mixed back-to-back and idle gaps.
    for (int k = 0; k < 40; k++) begin
      s = rnd_state();
      for (int j = 0; j < 8; j++) begin
        issue(s, 6'($urandom), ns, r);
        s = ns;
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    hold_check();

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d responses missing, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
